// File: rtl/quad_step_decoder_pkg.sv
// Shared definitions for the quadrature/step decoder: the AB phase codes,
// the decode-result type and the pure transition decoder.
// When QDEC_GLITCH_FILTER_EN is defined, each synchronised phase also goes
// through a two-cycle stability filter, which adds FILTER_LAT cycles of latency.
package quad_pkg;

  // Phase codes as {A, B}. Up order is PH0->PH1->PH2->PH3->PH0.
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FILTER_LAT = 2;
`else
  localparam int FILTER_LAT = 0;
`endif

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2,
    ILLEGAL = 2'd3
  } dec_e;

  // Phase that follows ph when moving in the up direction.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH3;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

  // Classify one sample-to-sample transition. A change of both bits at
  // once cannot be ordered, so it is reported as ILLEGAL.
  function automatic dec_e decode(input logic [1:0] prev, input logic [1:0] cur);
    dec_e res;
    if (cur == prev)               res = NONE;
    else if (cur == next_up(prev)) res = UP;
    else if (prev == next_up(cur)) res = DOWN;
    else                           res = ILLEGAL;
    return res;
  endfunction

endpackage

// File: rtl/quad_step_decoder_sync_ff.sv
// Single-bit synchroniser for one quadrature phase: SYNC_STAGES flops
// (legal range 2..4) with asynchronous active-high reset to 0.
// With QDEC_GLITCH_FILTER_EN defined, the synchronised level is only passed
// on after it has been seen on two consecutive cycles, so single-cycle
// glitches are swallowed at the cost of two extra cycles of latency.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the asynchronous input through the synchroniser chain.
  // NOTE: the chain is reset so the decoder sees a defined 0 level while
  // priming; it is not a memory, so resetting it costs nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

`ifdef QDEC_GLITCH_FILTER_EN
  logic r_d1;
  logic r_filt;
  logic w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Accept a new level only when the last two synchronised samples agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d1   <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_d1 <= w_sync;
      if (w_sync == r_d1) r_filt <= r_d1;
    end
  end

  assign o_q = r_filt;
`else
  assign o_q = r_sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature/step decoder: synchronises phases A/B, decodes Gray-code
// transitions into step pulses plus direction, keeps a WIDTH-bit wrapping
// position count and a sticky error for illegal (double-bit) transitions.
// Optional QDEC_GLITCH_FILTER_EN adds a per-phase two-cycle glitch filter
// (latency SYNC_STAGES+3 instead of SYNC_STAGES+1).
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a_in,
  input  logic             b_in,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  // Cycles after reset release before the phase path carries real input
  // levels; decoding before then would compare against reset zeros.
  localparam int PRIME_CYCLES = SYNC_STAGES + FILTER_LAT;
  localparam int PCW          = $clog2(PRIME_CYCLES + 1);

  logic             w_a;
  logic             w_b;
  logic [1:0]       w_cur_ab;
  dec_e             w_dec;
  logic             w_at_max;
  logic             w_at_zero;

  logic [1:0]       r_prev_ab;
  logic [PCW-1:0]   r_prime_cnt;
  logic             r_primed;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_step;
  logic             r_wrap;
  logic             r_err;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .i_d (a_in),
    .o_q (w_a)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .i_d (b_in),
    .o_q (w_b)
  );

  assign w_cur_ab  = {w_a, w_b};
  assign w_dec     = decode(r_prev_ab, w_cur_ab);
  assign w_at_max  = (r_count == {WIDTH{1'b1}});
  assign w_at_zero = (r_count == '0);

  // Track the previous sample every cycle and prime once the pipe is full.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_ab   <= PH0;
      r_prime_cnt <= '0;
      r_primed    <= 1'b0;
    end else begin
      r_prev_ab <= w_cur_ab;
      if (r_prime_cnt != PCW'(PRIME_CYCLES)) r_prime_cnt <= r_prime_cnt + PCW'(1);
      if (r_prime_cnt == PCW'(PRIME_CYCLES)) r_primed <= 1'b1;
    end
  end

  // Apply the decoded transition to count/dir/err; clr wins over a step
  // and works even while decoding is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      if (clr) begin
        r_count <= '0;
        r_err   <= 1'b0;
      end else if (en && r_primed) begin
        case (w_dec)
          UP: begin
            r_count <= r_count + WIDTH'(1);
            r_dir   <= 1'b1;
            r_step  <= 1'b1;
            r_wrap  <= w_at_max;
          end
          DOWN: begin
            r_count <= r_count - WIDTH'(1);
            r_dir   <= 1'b0;
            r_step  <= 1'b1;
            r_wrap  <= w_at_zero;
          end
          ILLEGAL: r_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign count = r_count;
  assign dir   = r_dir;
  assign step  = r_step;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Quadrature/step decoder that drives the team's up/down counter family from the input side.
- Samples two asynchronous phase inputs A/B and synchronises them.
- Decodes Gray-code transitions into step pulses plus direction.
- Maintains a WIDTH-bit wrapping position count, with sticky error detection for illegal transitions.

Parameters:
- WIDTH, 4, position counter width in bits; count wraps modulo 2^WIDTH.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser; legal range 2..4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  decode enable; when low, input sampling continues but count, step, dir, wrap and err hold.
- clr  input  1  synchronous clear of count and err.
- a_in  input  1  phase A, asynchronous to clk.
- b_in  input  1  phase B, asynchronous to clk.
- count  output  WIDTH  current position.
- dir  output  1  direction of the last accepted step: 1 = up, 0 = down.
- step  output  1  one-cycle pulse per accepted step.
- wrap  output  1  one-cycle pulse when count wraps (max->0 up, or 0->max down).
- err  output  1  sticky flag: illegal two-bit transition seen.

Behaviour:
- Reset, asynchronous on rst high:
  - Synchronisers, prev_ab and primed are cleared to 0.
  - Outputs: count=0, dir=0, step=0, wrap=0, err=0.
- Priming:
  - The first synchronised sample after reset release loads prev_ab and sets primed.
  - No decode happens on that cycle, so there is no false err when the inputs rest at 11.
- Decode, on cur_ab vs prev_ab, every cycle once primed:
  - Up sequence 00->01->11->10->00: step=1, dir=1, count+1.
  - Down sequence 00->10->11->01->00: step=1, dir=0, count-1.
  - cur == prev: no step; dir holds.
  - Both bits changed (00<->11, 01<->10): err<=1, no step, count holds, dir holds.
  - prev_ab<=cur_ab every cycle regardless of en.
- Arithmetic: count is unsigned modulo 2^WIDTH. wrap pulses in the same cycle as the wrapping step.
- Latency: an edge on a_in/b_in appears as step/count SYNC_STAGES+1 rising clk edges later. step, wrap and count update in the same cycle.
- en low:
  - step, wrap and err updates are suppressed.
  - Transitions occurring while disabled are lost, not accumulated.
- clr high:
  - count<=0 and err<=0; step=0, wrap=0.
  - clr beats a simultaneous step.
  - clr acts even when en is low.
- Reset mid-motion: immediate clear. The decoder re-primes on the next sample, so no spurious step or err.
- Max step rate: one transition per clk. Faster input produces err, not silent miscount.

Optional Feature:
- Macro: QDEC_GLITCH_FILTER_EN.
- Defined:
  - Each synchronised phase passes a filter that accepts a new level only after it is stable for 2 consecutive cycles.
  - Latency becomes SYNC_STAGES+3 cycles.
  - Single-cycle glitches on a_in or b_in produce no step and no err.
- Undefined: no filter; latency SYNC_STAGES+1; a one-cycle glitch produces a step followed by a reverse step.

Decomposition:
- Package quad_pkg holds:
  - Localparams for the AB phase codes PH0=2'b00, PH1=2'b01, PH2=2'b11, PH3=2'b10.
  - A decode-result type {NONE, UP, DOWN, ILLEGAL}.
  - A pure function decode(prev, cur) returning that type.
- Sub-module sync_ff (one instance per phase):
  - Parameterised SYNC_STAGES chain with asynchronous active-high reset to 0.
  - Also hosts the optional glitch filter under the macro.

Test Plan:
- Reset and prime: drive a_in=1, b_in=1, then release rst -> after SYNC_STAGES+1 cycles count=0, err=0, step never pulsed.
- Up count and wrap: WIDTH=4, 16 up transitions from count=14 -> count walks 15 then 0, wrap pulses once at the 15->0 step, dir=1, 16 step pulses.
- Down count and wrap: from count=0, one down transition (00->10) -> count=15, wrap=1 for one cycle, dir=0.
- Illegal transition: ab 00->11 in one cycle -> err=1 and stays set, count unchanged; then assert clr -> err=0, count=0.
- en/clr interaction: en=0 during 3 up transitions -> count unchanged, no step. Then clr and an up step in the same cycle -> count=0, step=0.
- Glitch (macro defined): 1-cycle pulse on a_in -> no step, no err. Macro undefined, same stimulus -> up step then down step, count back to its original value.
